// File: rtl/abh_pkg.sv
// Shared CPU address-path encodings: ABL/ABH base selects and ABH FSM states.
package abh_pkg;

  // ABL low-byte base select (companion stage feeding CO into ABH CI)
  typedef enum logic [2:0] {
    ABL_HOLD = 3'b000,
    ABL_ZP   = 3'b001,
    ABL_DB   = 3'b011,
    ABL_AHL  = 3'b100,
    ABL_PC   = 3'b101
  } abl_op_e;

  // ABH high-byte base select
  typedef enum logic [2:0] {
    ABH_HOLD = 3'b000,
    ABH_ZP   = 3'b001,
    ABH_STK  = 3'b010,
    ABH_DB   = 3'b011,
    ABH_AHH  = 3'b100,
    ABH_PC   = 3'b101,
    ABH_VEC  = 3'b110,
    ABH_RSVD = 3'b111
  } abh_op_e;

  localparam logic [7:0] ABH_STACK_PAGE  = 8'h01;
  localparam logic [7:0] ABH_VECTOR_PAGE = 8'hFF;

  typedef enum logic {
    ABH_IDLE  = 1'b0,
    ABH_FIXUP = 1'b1
  } abh_state_e;

endpackage

// File: rtl/abh.sv
// Address bus high generator: base mux + carry adder, AHH hold register,
// and a one-cycle page-cross fixup FSM that stalls the sequencer.
module abh
  import abh_pkg::*;
#(
  parameter bit         FIXUP_EN  = 1'b1,
  parameter logic [7:0] ABH_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CI,
  input  logic [7:0] PCH,
  input  logic [7:0] DBH,
  input  logic [2:0] op,
  input  logic       defer,
  input  logic       ld_ahh,
  output logic [7:0] ABH,
  output logic [7:0] AHH,
  output logic       stall
);

  abh_state_e state_q, state_d;
  logic [7:0] abh_q, abh_d;
  logic [7:0] ahh_q, ahh_d;
  logic [7:0] base;

  // Base select; AHH reads the registered value, so a same-cycle load is not seen
  always_comb begin
    base = abh_q;
    case (abh_op_e'(op))
      ABH_HOLD: base = abh_q;
      ABH_ZP:   base = 8'h00;
      ABH_STK:  base = ABH_STACK_PAGE;
      ABH_DB:   base = DBH;
      ABH_AHH:  base = ahh_q;
      ABH_PC:   base = PCH;
      ABH_VEC:  base = ABH_VECTOR_PAGE;
      default:  base = abh_q;
    endcase
  end

  // Next-state: immediate or deferred carry, fixup increment, AHH load
  always_comb begin
    state_d = state_q;
    abh_d   = abh_q;
    ahh_d   = ld_ahh ? DBH : ahh_q;
    if (state_q == ABH_FIXUP) begin
      abh_d   = abh_q + 8'h01;
      state_d = ABH_IDLE;
    end else if (FIXUP_EN && defer) begin
      abh_d   = base;
      state_d = CI ? ABH_FIXUP : ABH_IDLE;
    end else begin
      abh_d = base + {7'b0, CI};
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ABH_IDLE;
      abh_q   <= ABH_RESET;
      ahh_q   <= '0;
    end else begin
      state_q <= state_d;
      abh_q   <= abh_d;
      ahh_q   <= ahh_d;
    end
  end

  assign ABH   = abh_q;
  assign AHH   = ahh_q;
  assign stall = (state_q == ABH_FIXUP);

endmodule

// File: tb/tb_abh.sv
// Self-checking bench for abh: directed vector table, reset corner cases,
// and randomized traffic against a reference model, on FIXUP_EN=1 and =0.
module tb_abh;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       CI;
  logic [7:0] PCH, DBH;
  logic [2:0] op;
  logic       defer, ld_ahh;
  logic [7:0] abh0, ahh0, abh1, ahh1;
  logic       stall0, stall1;

  int checks = 0;
  int failures = 0;

  abh #(.FIXUP_EN(1'b1), .ABH_RESET(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .CI(CI), .PCH(PCH), .DBH(DBH), .op(op),
    .defer(defer), .ld_ahh(ld_ahh), .ABH(abh0), .AHH(ahh0), .stall(stall0)
  );

  abh #(.FIXUP_EN(1'b0), .ABH_RESET(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .CI(CI), .PCH(PCH), .DBH(DBH), .op(op),
    .defer(defer), .ld_ahh(ld_ahh), .ABH(abh1), .AHH(ahh1), .stall(stall1)
  );

  always #5 clk = ~clk;

  // Reference model: pending-fixup flag per instance, plain modulo-256 arithmetic
  int m_abh0, m_abh1, m_ahh;
  bit m_pend0, m_pend1;

  function automatic int base_of(input logic [2:0] o, input int cur, input int hold);
    int b;
    case (o)
      3'd1: b = 0;
      3'd2: b = 1;
      3'd3: b = int'(DBH);
      3'd4: b = hold;
      3'd5: b = int'(PCH);
      3'd6: b = 255;
      default: b = cur;
    endcase
    return b;
  endfunction

  task automatic model_reset();
    m_abh0 = 0; m_abh1 = 0; m_ahh = 0; m_pend0 = 0; m_pend1 = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int c;
    c = CI ? 1 : 0;
    if (m_pend0) begin
      m_abh0 = (m_abh0 + 1) % 256;
      m_pend0 = 0;
    end else if (defer) begin
      m_abh0 = base_of(op, m_abh0, m_ahh);
      m_pend0 = CI;
    end else begin
      m_abh0 = (base_of(op, m_abh0, m_ahh) + c) % 256;
    end
    m_abh1 = (base_of(op, m_abh1, m_ahh) + c) % 256;
    if (ld_ahh) m_ahh = int'(DBH);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".abh0"},   int'(abh0),   m_abh0);
    chk({tag, ".ahh0"},   int'(ahh0),   m_ahh);
    chk({tag, ".stall0"}, int'(stall0), m_pend0 ? 1 : 0);
    chk({tag, ".abh1"},   int'(abh1),   m_abh1);
    chk({tag, ".ahh1"},   int'(ahh1),   m_ahh);
    chk({tag, ".stall1"}, int'(stall1), 0);
  endtask

  task automatic drive(input logic [2:0] o, input logic c, input logic d,
                       input logic [7:0] db, input logic [7:0] pc, input logic ld);
    op = o; CI = c; defer = d; DBH = db; PCH = pc; ld_ahh = ld;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       ci, dfr, ld;
    logic [7:0] dbh, pch;
    logic [7:0] e_abh0, e_ahh, e_abh1;
    logic       e_stall0;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] o, input logic c, input logic d,
                              input logic [7:0] db, input logic [7:0] pc, input logic ld,
                              input logic [7:0] ea0, input logic [7:0] eh,
                              input logic [7:0] ea1, input logic es);
    vec_t v;
    v.op = o; v.ci = c; v.dfr = d; v.dbh = db; v.pch = pc; v.ld = ld;
    v.e_abh0 = ea0; v.e_ahh = eh; v.e_abh1 = ea1; v.e_stall0 = es;
    return v;
  endfunction

  vec_t vt[15];

  initial begin
    // op  ci dfr dbh    pch    ld   abh0   ahh    abh1   stall0
    vt[0]  = mk(3'b000, 0, 0, 8'h12, 8'h00, 1, 8'h00, 8'h12, 8'h00, 0); // load AHH
    vt[1]  = mk(3'b100, 0, 0, 8'h34, 8'h00, 0, 8'h12, 8'h12, 8'h12, 0); // absolute
    vt[2]  = mk(3'b011, 1, 0, 8'h12, 8'h00, 0, 8'h13, 8'h12, 8'h13, 0); // immediate carry
    vt[3]  = mk(3'b110, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h12, 8'h00, 0); // FF+1 wraps
    vt[4]  = mk(3'b101, 1, 0, 8'h00, 8'h7F, 0, 8'h80, 8'h12, 8'h80, 0); // PCH + carry
    vt[5]  = mk(3'b010, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h12, 8'h01, 0); // stack page
    vt[6]  = mk(3'b111, 1, 0, 8'h00, 8'h00, 0, 8'h02, 8'h12, 8'h02, 0); // reserved = hold
    vt[7]  = mk(3'b001, 1, 0, 8'h00, 8'h00, 0, 8'h01, 8'h12, 8'h01, 0); // zero page + carry
    vt[8]  = mk(3'b000, 0, 0, 8'h00, 8'h00, 0, 8'h01, 8'h12, 8'h01, 0); // hold
    vt[9]  = mk(3'b011, 1, 1, 8'h12, 8'h00, 0, 8'h12, 8'h12, 8'h13, 1); // page cross
    vt[10] = mk(3'b110, 1, 1, 8'h55, 8'h00, 1, 8'h13, 8'h55, 8'h00, 0); // fixup, AHH loads
    vt[11] = mk(3'b100, 0, 0, 8'h66, 8'h00, 1, 8'h55, 8'h66, 8'h55, 0); // old AHH read
    vt[12] = mk(3'b110, 1, 1, 8'h00, 8'h00, 0, 8'hFF, 8'h66, 8'h00, 1); // deferred from FF
    vt[13] = mk(3'b101, 0, 0, 8'h00, 8'h7F, 0, 8'h00, 8'h66, 8'h7F, 0); // fixup wraps
    vt[14] = mk(3'b011, 0, 1, 8'h20, 8'h00, 0, 8'h20, 8'h66, 8'h20, 0); // defer, no carry

    // Reset with random inputs
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk);
      #1;
      chk("reset.abh0", int'(abh0), 0);
      chk("reset.ahh0", int'(ahh0), 0);
      chk("reset.stall0", int'(stall0), 0);
    end
    drive(3'b000, 0, 0, 8'h00, 8'h00, 0);
    rst_n = 1'b1;
    cycle();
    chk_model("post_reset");
    chk("post_reset.abh0_zero", int'(abh0), 0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].op, vt[i].ci, vt[i].dfr, vt[i].dbh, vt[i].pch, vt[i].ld);
      cycle();
      chk($sformatf("vec%0d.abh0", i),   int'(abh0),   int'(vt[i].e_abh0));
      chk($sformatf("vec%0d.ahh0", i),   int'(ahh0),   int'(vt[i].e_ahh));
      chk($sformatf("vec%0d.stall0", i), int'(stall0), int'(vt[i].e_stall0));
      chk($sformatf("vec%0d.abh1", i),   int'(abh1),   int'(vt[i].e_abh1));
      chk($sformatf("vec%0d.stall1", i), int'(stall1), 0);
    end

    // Reset asserted in the middle of FIXUP
    drive(3'b011, 1, 1, 8'h12, 8'h00, 0);
    cycle();
    chk("midfix.enter_stall", int'(stall0), 1);
    chk("midfix.enter_abh", int'(abh0), 8'h12);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midfix.async_abh", int'(abh0), 0);
    chk("midfix.async_stall", int'(stall0), 0);
    @(negedge clk);
    drive(3'b000, 0, 0, 8'h00, 8'h00, 0);
    rst_n = 1'b1;
    cycle();
    chk("midfix.no_increment", int'(abh0), 0);
    chk("midfix.stall_after", int'(stall0), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
